// File: rtl/mu0_mem_pkg.sv
// Shared types and default sizes for the MU0 memory arbiter.
package mu0_mem_pkg;

    localparam int unsigned DEF_ADDR_W   = 12;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_MAX_WAIT = 4;

    // 2-bit encoding; the spare code 2'b11 is recovered to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/mu0_arb_pick.sv
// Combinational winner selection: CPU has priority unless the debug port
// has already lost MAX_WAIT consecutive arbitrations.
module mu0_arb_pick
    import mu0_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
    parameter int unsigned WAIT_W   = 3
) (
    input  logic              i_cpu_el,
    input  logic              i_dbg_el,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    output logic              o_any_grant,
    output owner_t            o_winner,
    output logic [WAIT_W-1:0] o_next_wait
);

    logic w_starved;
    logic w_dbg_wins;

    assign w_starved  = (i_wait_cnt == WAIT_W'(MAX_WAIT));
    assign w_dbg_wins = i_dbg_el & (~i_cpu_el | w_starved);

    // Select winner and compute the saturating starvation count
    always_comb begin
        o_any_grant = i_cpu_el | i_dbg_el;
        o_winner    = w_dbg_wins ? OWNER_DBG : OWNER_CPU;
        o_next_wait = i_wait_cnt;
        if (w_dbg_wins) begin
            o_next_wait = '0;
        end else if (i_dbg_el && !w_starved) begin
            o_next_wait = WAIT_W'(i_wait_cnt + 1'b1);
        end
    end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Serialises CPU and debug/loader accesses onto one single-port synchronous
// memory through an IDLE/ISSUE/RESP FSM.
module mu0_mem_arbiter
    import mu0_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_write,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    arb_state_t        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    owner_t            r_owner;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cpu_gnt;
    logic              r_dbg_gnt;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_cpu_rvalid;
    logic              r_dbg_rvalid;
    logic              r_cpu_rdata;
    logic [DATA_W-1:0] r_cpu_rdata_q;
    logic [DATA_W-1:0] r_dbg_rdata_q;
    logic              r_busy;

    logic              w_cpu_el;
    logic              w_dbg_el;
    logic              w_any_grant;
    owner_t            w_winner;
    logic [WAIT_W-1:0] w_next_wait;

    assign w_cpu_el = cpu_req & ~dbg_lock;
    assign w_dbg_el = dbg_req;

    mu0_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_pick (
        .i_cpu_el    (w_cpu_el),
        .i_dbg_el    (w_dbg_el),
        .i_wait_cnt  (r_wait_cnt),
        .o_any_grant (w_any_grant),
        .o_winner    (w_winner),
        .o_next_wait (w_next_wait)
    );

    // Issue/response FSM with registered grants, strobes and rvalids
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_wait_cnt    <= '0;
            r_owner       <= OWNER_CPU;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cpu_gnt     <= 1'b0;
            r_dbg_gnt     <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            r_dbg_rvalid  <= 1'b0;
            r_cpu_rdata   <= 1'b0;
            r_cpu_rdata_q <= '0;
            r_dbg_rdata_q <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_rdata  <= 1'b0;
            // Keep the read word once the RESP cycle ends
            if (r_cpu_rvalid) r_cpu_rdata_q <= mem_rdata;
            if (r_dbg_rvalid) r_dbg_rdata_q <= mem_rdata;
            case (r_state)
                IDLE, RESP: begin
                    r_wait_cnt <= w_next_wait;
                    if (w_any_grant) begin
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                        r_owner <= w_winner;
                        if (w_winner == OWNER_DBG) begin
                            r_write     <= dbg_write;
                            r_addr      <= dbg_addr;
                            r_wdata     <= dbg_wdata;
                            r_dbg_gnt   <= 1'b1;
                            r_mem_read  <= ~dbg_write;
                            r_mem_write <= dbg_write;
                        end else begin
                            r_write     <= cpu_write;
                            r_addr      <= cpu_addr;
                            r_wdata     <= cpu_wdata;
                            r_cpu_gnt   <= 1'b1;
                            r_mem_read  <= ~cpu_write;
                            r_mem_write <= cpu_write;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_state <= RESP;
                    r_busy  <= 1'b1;
                    if (!r_write) begin
                        if (r_owner == OWNER_DBG) r_dbg_rvalid <= 1'b1;
                        else                      r_cpu_rvalid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Memory data arrives during RESP, so it is bypassed to the owner in that
    // cycle and the registered copy covers every later cycle.
    assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : r_cpu_rdata_q;
    assign dbg_rdata  = r_dbg_rvalid ? mem_rdata : r_dbg_rdata_q;
    assign cpu_gnt    = r_cpu_gnt;
    assign dbg_gnt    = r_dbg_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dbg_rvalid = r_dbg_rvalid;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign busy       = r_busy;

    logic w_unused;
    assign w_unused = r_cpu_rdata;

endmodule

// File: doc/mu0_mem_arbiter.md
Name: mu0_mem_arbiter

Overview:
- Shares one single-port synchronous 16-bit memory (1-cycle read latency) between the MU0 CPU port and a debug/loader port.
- Serialises accesses through an issue/response FSM.
- Fixed CPU priority, with a starvation bound for the debug port.
- A lock input lets the host load programs while CPU accesses are held off.

Parameters:
ADDR_W, 12, address width of both requesters and memory
DATA_W, 16, data width
MAX_WAIT, 4, number of consecutive lost arbitrations after which a pending debug request wins

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_write  in  1  1=write, 0=read; valid with cpu_req
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  one-cycle pulse, CPU access issued to memory this cycle
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid (reads only)
cpu_rdata  out  DATA_W  CPU read data
dbg_req  in  1  debug access request, held until dbg_gnt
dbg_write  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_lock  in  1  1=CPU requests never granted
dbg_gnt  out  1  one-cycle pulse, debug access issued
dbg_rvalid  out  1  one-cycle pulse, dbg_rdata valid
dbg_rdata  out  DATA_W  debug read data
mem_addr  out  ADDR_W  memory address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_read
busy  out  1  1 in ISSUE or RESP

Behaviour:
- Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, wait_cnt=0, latched owner/op/addr/wdata=0.
  - All outputs 0.
- FSM states:
  - IDLE: no memory strobe.
  - ISSUE: mem_* driven from the latched request; gnt of the owner=1.
  - RESP: for a read, owner's rvalid=1 and rdata=mem_rdata; for a write, no rvalid.
- Transitions:
  - IDLE->ISSUE if any eligible request, else stay in IDLE.
  - ISSUE->RESP always.
  - RESP->ISSUE if any eligible request (back-to-back), else RESP->IDLE.
- Sampling:
  - Requests are sampled and latched only at edges leaving IDLE or RESP, never at the edge leaving ISSUE.
  - A requester must drop req by the RESP cycle unless it wants a further access; a req still high in RESP counts as a new request.
- Eligibility:
  - cpu eligible = cpu_req & ~dbg_lock.
  - dbg eligible = dbg_req.
- Arbitration:
  - CPU wins when both are eligible, unless wait_cnt==MAX_WAIT, in which case dbg wins.
  - wait_cnt increments (saturating at MAX_WAIT) when dbg lost an arbitration with dbg_req high.
  - wait_cnt clears when dbg wins.
- Latency and throughput:
  - Request in cycle N (IDLE) -> gnt and mem strobe in N+1 -> rvalid/rdata in N+2.
  - Sustained throughput is one access per 2 cycles.
- rdata outputs are registered copies of mem_rdata, taken at the RESP cycle. They hold their value after rvalid falls until the next read by that owner.
- mem_read and mem_write are never both 1. At most one gnt and one rvalid is high per cycle.
- mem_addr and mem_wdata hold their last values outside ISSUE. Strobes are 0 outside ISSUE.
- dbg_lock rising while a CPU access is in ISSUE/RESP does not abort it; the lock applies from the next arbitration.
- Reset mid-operation:
  - Returns to IDLE immediately; an ISSUE-cycle write strobe is deasserted asynchronously.
  - Pending rvalid is lost; requesters must re-request.
- The FSM uses a 2-bit state encoding; the unused code returns to IDLE.

Decomposition:
- Package mu0_mem_pkg:
  - arb_state_t enum (IDLE, ISSUE, RESP).
  - owner_t enum (OWNER_CPU, OWNER_DBG).
  - Default widths ADDR_W/DATA_W as localparams.
- One sub-module: mu0_arb_pick.
  - Purely combinational; inputs: cpu eligible, dbg eligible, wait_cnt.
  - Outputs: any_grant, winner owner_t, next wait_cnt.
  - Instantiated once by mu0_mem_arbiter.

Test Plan:
- CPU read: mem holds 16'h1234 at 12'h005; cpu_req=1, cpu_write=0, cpu_addr=12'h005 in cycle 0 -> cpu_gnt and mem_read with mem_addr=12'h005 in cycle 1; cpu_rvalid=1, cpu_rdata=16'h1234 in cycle 2; busy=0 in cycle 3.
- Debug write then CPU read: dbg writes 16'hBEEF to 12'h0FF; CPU then reads 12'h0FF -> mem_write=1 exactly one cycle; CPU read returns 16'hBEEF; dbg_rvalid is never asserted.
- Contention/starvation: cpu_req and dbg_req held high continuously, MAX_WAIT=4 -> grant order CPU,CPU,CPU,CPU,DBG,CPU,...; grants every 2nd cycle; never both gnt high.
- Lock: dbg_lock=1, cpu_req high for 20 cycles -> cpu_gnt stays 0; dbg_lock=0 -> cpu_gnt 1 cycle after the next IDLE/RESP sample.
- Back-to-back: cpu reads 12'h001 and 12'h002 with req held through RESP -> second gnt in the cycle immediately after the first rvalid, with no IDLE between them.
- Async reset: assert rst mid-cycle during ISSUE of a write -> mem_write, gnt and busy drop before the next clk edge; state=IDLE and wait_cnt=0 after rst release.
